// File: rtl/s1_decode_stage.sv
// rtl/s1_decode_stage.sv - stage-1 decode, 32-entry register file with write-through, stage-2 bundle register
// Stalls fetch for one cycle on a read-after-write against the instruction sitting in stage 2.
module s1_decode_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       S1_Instr,
  input  logic              S1_Valid,
  input  logic              Flush,
  input  logic              S3_WriteEnable,
  input  logic [REG_AW-1:0] S3_WriteSelect,
  input  logic [DATA_W-1:0] S3_WriteData,
  output logic              Stall,
  output logic [2:0]        S2_ALUOp,
  output logic [DATA_W-1:0] S2_ReadData1,
  output logic [DATA_W-1:0] S2_ReadData2,
  output logic [DATA_W-1:0] S2_Imm,
  output logic              S2_DataSrc,
  output logic [REG_AW-1:0] S2_WriteSelect,
  output logic              S2_WriteEnable
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] rf [NREG];

  logic              is_alu;
  logic              data_src;
  logic [2:0]        alu_op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [DATA_W-1:0] imm_ext;
  logic              uses_rs2;
  logic              hazard;
  logic              bubble;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;

  assign is_alu   = (S1_Instr[31:30] == 2'b01);
  assign data_src = S1_Instr[29];
  assign alu_op   = S1_Instr[28:26];
  assign rd       = S1_Instr[21 +: REG_AW];
  assign rs1      = S1_Instr[16 +: REG_AW];
  assign rs2      = S1_Instr[11 +: REG_AW];
  assign imm_ext  = {{(DATA_W-16){S1_Instr[15]}}, S1_Instr[15:0]};

  // not (000) and mov (001) are unary, so rs2 only matters for binary register-register ops
  assign uses_rs2 = !data_src && (alu_op != 3'b000) && (alu_op != 3'b001);

  assign hazard = S2_WriteEnable && (S2_WriteSelect != '0) &&
                  ((S2_WriteSelect == rs1) || (uses_rs2 && (S2_WriteSelect == rs2)));

  assign Stall  = S1_Valid && is_alu && hazard;
  assign bubble = Flush || Stall || !S1_Valid || !is_alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (S3_WriteEnable && (S3_WriteSelect != '0)) begin
      rf[S3_WriteSelect] <= S3_WriteData;
    end
  end

  // Write-through: a same-cycle writeback wins over the stale entry so distance-2 hazards need no stall
  always_comb begin
    read_data1 = rf[rs1];
    if (rs1 == '0) begin
      read_data1 = '0;
    end else if (S3_WriteEnable && (S3_WriteSelect == rs1)) begin
      read_data1 = S3_WriteData;
    end
  end

  always_comb begin
    read_data2 = rf[rs2];
    if (rs2 == '0) begin
      read_data2 = '0;
    end else if (S3_WriteEnable && (S3_WriteSelect == rs2)) begin
      read_data2 = S3_WriteData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S2_ALUOp       <= '0;
      S2_ReadData1   <= '0;
      S2_ReadData2   <= '0;
      S2_Imm         <= '0;
      S2_DataSrc     <= 1'b0;
      S2_WriteSelect <= '0;
      S2_WriteEnable <= 1'b0;
    end else if (bubble) begin
      S2_ALUOp       <= '0;
      S2_ReadData1   <= '0;
      S2_ReadData2   <= '0;
      S2_Imm         <= '0;
      S2_DataSrc     <= 1'b0;
      S2_WriteSelect <= '0;
      S2_WriteEnable <= 1'b0;
    end else begin
      S2_ALUOp       <= alu_op;
      S2_ReadData1   <= read_data1;
      S2_ReadData2   <= read_data2;
      S2_Imm         <= imm_ext;
      S2_DataSrc     <= data_src;
      S2_WriteSelect <= rd;
      S2_WriteEnable <= (rd != '0);
    end
  end

endmodule

// File: tb/tb_s1_decode_stage.sv
// tb/tb_s1_decode_stage.sv - scoreboard bench for s1_decode_stage with directed hand-computed vectors
module tb_s1_decode_stage;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic        ds;
    logic [4:0]  ws;
    logic        we;
  } s2_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] S1_Instr;
  logic        S1_Valid;
  logic        Flush;
  logic        S3_WriteEnable;
  logic [4:0]  S3_WriteSelect;
  logic [31:0] S3_WriteData;
  logic        Stall;
  logic [2:0]  S2_ALUOp;
  logic [31:0] S2_ReadData1;
  logic [31:0] S2_ReadData2;
  logic [31:0] S2_Imm;
  logic        S2_DataSrc;
  logic [4:0]  S2_WriteSelect;
  logic        S2_WriteEnable;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  step_no = 0;
  s2_t exp_q[$];
  s2_t bub;

  s1_decode_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .S1_Instr(S1_Instr), .S1_Valid(S1_Valid), .Flush(Flush),
    .S3_WriteEnable(S3_WriteEnable), .S3_WriteSelect(S3_WriteSelect), .S3_WriteData(S3_WriteData),
    .Stall(Stall), .S2_ALUOp(S2_ALUOp), .S2_ReadData1(S2_ReadData1), .S2_ReadData2(S2_ReadData2),
    .S2_Imm(S2_Imm), .S2_DataSrc(S2_DataSrc), .S2_WriteSelect(S2_WriteSelect),
    .S2_WriteEnable(S2_WriteEnable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] cls, input logic ds, input logic [2:0] op,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [15:0] imm);
    return {cls, ds, op, rd, rs1, imm};
  endfunction

  function automatic s2_t ex(input logic [2:0] op, input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] imm, input logic ds, input logic [4:0] ws,
                             input logic we);
    s2_t e;
    e.op = op; e.r1 = r1; e.r2 = r2; e.imm = imm; e.ds = ds; e.ws = ws; e.we = we;
    return e;
  endfunction

  task automatic check_s2(input string tag, input s2_t e);
    chk({tag, " alu_op"}, {29'd0, S2_ALUOp}, {29'd0, e.op});
    chk({tag, " rd1"},    S2_ReadData1, e.r1);
    chk({tag, " rd2"},    S2_ReadData2, e.r2);
    chk({tag, " imm"},    S2_Imm, e.imm);
    chk({tag, " ds"},     {31'd0, S2_DataSrc}, {31'd0, e.ds});
    chk({tag, " ws"},     {27'd0, S2_WriteSelect}, {27'd0, e.ws});
    chk({tag, " we"},     {31'd0, S2_WriteEnable}, {31'd0, e.we});
  endtask

  // Drive one cycle of stimulus on the falling edge, check Stall, queue what stage 2 must hold next
  task automatic step(input logic [31:0] instr, input logic valid, input logic flush,
                      input logic we, input logic [4:0] ws, input logic [31:0] wd,
                      input logic exp_stall, input s2_t e);
    @(negedge clk);
    S1_Instr = instr; S1_Valid = valid; Flush = flush;
    S3_WriteEnable = we; S3_WriteSelect = ws; S3_WriteData = wd;
    #1;
    step_no++;
    chk($sformatf("step%0d stall", step_no), {31'd0, Stall}, {31'd0, exp_stall});
    exp_q.push_back(e);
  endtask

  initial begin
    s2_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_s2($sformatf("sb%0d", step_no), e);
      end
    end
  end

  initial begin
    bub = '0;
    rst_n = 1'b0; S1_Instr = '0; S1_Valid = 1'b0; Flush = 1'b0;
    S3_WriteEnable = 1'b0; S3_WriteSelect = '0; S3_WriteData = '0;
    repeat (2) @(negedge clk);
    check_s2("reset", bub);
    chk("reset stall", {31'd0, Stall}, 32'd0);
    rst_n = 1'b1;

    // R3 = 5, then immediate add rd=4, rs1=3
    step(32'h0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h5, 1'b0, bub);
    step(mk(2'b01, 1'b1, 3'b101, 5'd4, 5'd3, 16'hFFFE), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         ex(3'b101, 32'h5, 32'h0, 32'hFFFF_FFFE, 1'b1, 5'd4, 1'b1));
    // add rd=7 (rs1=3, rs2=3), then dependent sub stalls one cycle
    step(mk(2'b01, 1'b0, 3'b101, 5'd7, 5'd3, 16'h1800), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         ex(3'b101, 32'h5, 32'h5, 32'h0000_1800, 1'b0, 5'd7, 1'b1));
    step(mk(2'b01, 1'b0, 3'b110, 5'd8, 5'd7, 16'h0000), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, bub);
    step(mk(2'b01, 1'b0, 3'b110, 5'd8, 5'd7, 16'h0000), 1'b1, 1'b0, 1'b1, 5'd7, 32'hA, 1'b0,
         ex(3'b110, 32'hA, 32'h0, 32'h0, 1'b0, 5'd8, 1'b1));
    // same-cycle bypass on rs2=9
    step(mk(2'b01, 1'b0, 3'b100, 5'd10, 5'd3, 16'h4800), 1'b1, 1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF,
         1'b0, ex(3'b100, 32'h5, 32'hDEAD_BEEF, 32'h0000_4800, 1'b0, 5'd10, 1'b1));
    // R0 write ignored, even through the bypass
    step(mk(2'b01, 1'b1, 3'b001, 5'd11, 5'd0, 16'h0001), 1'b1, 1'b0, 1'b1, 5'd0, 32'h1234, 1'b0,
         ex(3'b001, 32'h0, 32'h0, 32'h1, 1'b1, 5'd11, 1'b1));
    step(mk(2'b01, 1'b1, 3'b101, 5'd0, 5'd9, 16'h0002), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         ex(3'b101, 32'hDEAD_BEEF, 32'h0, 32'h2, 1'b1, 5'd0, 1'b0));
    step(mk(2'b01, 1'b0, 3'b011, 5'd12, 5'd0, 16'h0000), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         ex(3'b011, 32'h0, 32'h0, 32'h0, 1'b0, 5'd12, 1'b1));
    // class 00 reading the stage-2 destination: NOP, no stall
    step(mk(2'b00, 1'b1, 3'b101, 5'd14, 5'd12, 16'h0000), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, bub);
    step(mk(2'b01, 1'b0, 3'b101, 5'd13, 5'd3, 16'h0000), 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, bub);
    // S1_Valid=0 with a would-be hazard
    step(mk(2'b01, 1'b1, 3'b101, 5'd15, 5'd3, 16'h0010), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         ex(3'b101, 32'h5, 32'h0, 32'h10, 1'b1, 5'd15, 1'b1));
    step(mk(2'b01, 1'b1, 3'b101, 5'd21, 5'd15, 16'h0000), 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, bub);
    // Flush together with Stall
    step(mk(2'b01, 1'b1, 3'b101, 5'd16, 5'd3, 16'h0000), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         ex(3'b101, 32'h5, 32'h0, 32'h0, 1'b1, 5'd16, 1'b1));
    step(mk(2'b01, 1'b1, 3'b110, 5'd17, 5'd16, 16'h7FFF), 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, bub);
    step(mk(2'b01, 1'b1, 3'b110, 5'd17, 5'd16, 16'h7FFF), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         ex(3'b110, 32'h0, 32'h0, 32'h0000_7FFF, 1'b1, 5'd17, 1'b1));
    // mov ignores rs2; and uses it
    step(mk(2'b01, 1'b1, 3'b101, 5'd18, 5'd3, 16'h0000), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         ex(3'b101, 32'h5, 32'h0, 32'h0, 1'b1, 5'd18, 1'b1));
    step(mk(2'b01, 1'b0, 3'b001, 5'd19, 5'd3, 16'h9000), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         ex(3'b001, 32'h5, 32'h0, 32'hFFFF_9000, 1'b0, 5'd19, 1'b1));
    step(mk(2'b01, 1'b0, 3'b100, 5'd20, 5'd3, 16'h9800), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, bub);
    step(mk(2'b01, 1'b0, 3'b100, 5'd20, 5'd3, 16'h9800), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         ex(3'b100, 32'h5, 32'h0, 32'hFFFF_9800, 1'b0, 5'd20, 1'b1));

    // asynchronous reset in the middle of a stall
    @(negedge clk);
    S1_Instr = mk(2'b01, 1'b1, 3'b101, 5'd22, 5'd20, 16'h0000); S1_Valid = 1'b1; Flush = 1'b0;
    S3_WriteEnable = 1'b0; S3_WriteSelect = '0; S3_WriteData = '0;
    #1;
    chk("pre-reset stall", {31'd0, Stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_s2("async reset", bub);
    chk("async reset stall", {31'd0, Stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // register file cleared: R3 reads 0; ALUOp 010 passes through
    step(mk(2'b01, 1'b1, 3'b101, 5'd21, 5'd3, 16'h0004), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         ex(3'b101, 32'h0, 32'h0, 32'h4, 1'b1, 5'd21, 1'b1));
    step(mk(2'b01, 1'b1, 3'b010, 5'd22, 5'd9, 16'h0000), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         ex(3'b010, 32'h0, 32'h0, 32'h0, 1'b1, 5'd22, 1'b1));
    step(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, bub);

    repeat (2) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
